// File: rtl/ssd_pkg.sv
// Shared constants for the 7-segment capture block: active-low segment patterns
// (bit0=a .. bit6=g) and the number of multiplexed digits.
package ssd_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Result of classifying one segment pattern.
  typedef struct packed {
    logic [3:0] value;
    logic       is_digit;
    logic       is_blank;
  } seg_class_t;

endpackage

// File: rtl/ssd_pattern_dec.sv
// Combinational inverse of a HEX digit decoder: maps an active-low segment
// pattern back to its decimal value and classifies it as digit, blank or illegal.
module ssd_pattern_dec
  import ssd_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] value,
  output logic       is_digit,
  output logic       is_blank
);

  seg_class_t cls;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    cls.value    = 4'd0;
    cls.is_digit = 1'b1;
    cls.is_blank = 1'b0;
    case (seg_n)
      SEG_0:     cls.value = 4'd0;
      SEG_1:     cls.value = 4'd1;
      SEG_2:     cls.value = 4'd2;
      SEG_3:     cls.value = 4'd3;
      SEG_4:     cls.value = 4'd4;
      SEG_5:     cls.value = 4'd5;
      SEG_6:     cls.value = 4'd6;
      SEG_7:     cls.value = 4'd7;
      SEG_8:     cls.value = 4'd8;
      SEG_9:     cls.value = 4'd9;
      SEG_BLANK: begin
        cls.is_digit = 1'b0;
        cls.is_blank = 1'b1;
      end
      default:   cls.is_digit = 1'b0;
    endcase
  end

  assign value    = cls.value;
  assign is_digit = cls.is_digit;
  assign is_blank = cls.is_blank;

endmodule

// File: rtl/ssd_capture.sv
// Samples a multiplexed active-low 7-segment bus, waits for a stable dwell on a
// single digit, and reconstructs the value shown on each digit; flags illegal
// patterns and a dead scan.
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [6:0]                seg_n,
  input  logic [NUM_DIGITS-1:0]     an_n,
  output logic [4*NUM_DIGITS-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     valid,
  output logic                      upd,
  output logic                      err,
  output logic                      stale
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT - 1);

  // Sample register and the sample before it.
  logic [6:0]            seg_d, seg_q;
  logic [NUM_DIGITS-1:0] an_d, an_q;
  logic [6:0]            prev_seg_d, prev_seg_q;
  logic [NUM_DIGITS-1:0] prev_an_d, prev_an_q;

  logic [SW-1:0] stab_d, stab_q;
  logic [TW-1:0] tmo_d, tmo_q;

  logic [NUM_DIGITS-1:0][3:0] digits_d, digits_q;
  logic [NUM_DIGITS-1:0]      valid_d, valid_q;
  logic                       upd_d, upd_q;
  logic                       err_d, err_q;
  logic                       stale_d, stale_q;

  logic [3:0] dec_value;
  logic       dec_is_digit;
  logic       dec_is_blank;

  logic       qualified;
  logic       same;
  logic       capture;
  logic [1:0] active_idx;

  ssd_pattern_dec u_dec (
    .seg_n    (seg_q),
    .value    (dec_value),
    .is_digit (dec_is_digit),
    .is_blank (dec_is_blank)
  );

  always_comb begin
    qualified  = ($countones(~an_q) == 1);
    same       = (seg_q == prev_seg_q) && (an_q == prev_an_q);
    active_idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) active_idx = 2'(i);
    end
  end

  // Stability counter; a dwell captures once, when the count first reaches
  // STAB_MAX (a changed sample always starts a new dwell, even at STAB_MAX=1).
  always_comb begin
    seg_d      = seg_n;
    an_d       = an_n;
    prev_seg_d = seg_q;
    prev_an_d  = an_q;

    if (!qualified)           stab_d = '0;
    else if (!same)           stab_d = SW'(1);
    else if (stab_q == STAB_MAX) stab_d = stab_q;
    else                      stab_d = stab_q + SW'(1);

    capture = qualified && (stab_d == STAB_MAX) && !(same && (stab_q == STAB_MAX));
  end

  // Output registers and the dead-scan timeout; capture wins over expiry.
  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    upd_d    = 1'b0;
    stale_d  = 1'b0;
    tmo_d    = tmo_q + TW'(1);

    if (capture) begin
      upd_d               = 1'b1;
      tmo_d               = '0;
      valid_d[active_idx] = dec_is_digit;
      if (dec_is_digit) digits_d[active_idx] = dec_value;
      if (!dec_is_digit && !dec_is_blank) err_d = 1'b1;
    end else if (tmo_q == TMO_MAX) begin
      tmo_d   = '0;
      valid_d = '0;
      stale_d = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, and the reset
  // covers every flop, including the sample registers, so a dwell interrupted
  // by reset cannot complete afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q      <= '0;
      an_q       <= '0;
      prev_seg_q <= '0;
      prev_an_q  <= '0;
      stab_q     <= '0;
      tmo_q      <= '0;
      digits_q   <= '0;
      valid_q    <= '0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      seg_q      <= seg_d;
      an_q       <= an_d;
      prev_seg_q <= prev_seg_d;
      prev_an_q  <= prev_an_d;
      stab_q     <= stab_d;
      tmo_q      <= tmo_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
      stale_q    <= stale_d;
    end
  end

  assign digits = digits_q;
  assign valid  = valid_q;
  assign upd    = upd_q;
  assign err    = err_q;
  assign stale  = stale_q;

endmodule

// File: tb/tb_ssd_capture.sv
// Directed bench for ssd_capture: inputs change on the falling edge, outputs are
// observed on the falling edge, pulses are counted per hold interval.
module tb_ssd_capture;

  localparam int T = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  an_n = 4'hF;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic        upd;
  logic        err;
  logic        stale;

  int n_checks = 0;
  int n_errors = 0;
  int upd_n, stale_n, last_upd_at, last_stale_at;

  ssd_capture #(.STABLE_CYCLES(4), .TIMEOUT(T)) dut (
    .clk    (clk),
    .rst    (rst),
    .seg_n  (seg_n),
    .an_n   (an_n),
    .digits (digits),
    .valid  (valid),
    .upd    (upd),
    .err    (err),
    .stale  (stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    upd_n = 0; stale_n = 0; last_upd_at = -1; last_stale_at = -1;
  endtask

  // Drive one (anode, pattern) pair for n cycles, logging pulses by cycle index.
  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_n  = an;
    seg_n = seg;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (upd)   begin upd_n++;   last_upd_at   = k; end
      if (stale) begin stale_n++; last_stale_at = k; end
    end
  endtask

  initial begin
    clear_counts();
    hold(4'hF, 7'h7F, 3);
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_valid",  32'(valid),  32'h0);
    check("rst_upd",    32'(upd),    32'h0);
    check("rst_err",    32'(err),    32'h0);
    check("rst_stale",  32'(stale),  32'h0);
    rst = 1'b0;

    // 1: scan all four digits
    clear_counts();
    hold(4'b1110, 7'h24, 8);
    hold(4'b1101, 7'h30, 8);
    hold(4'b1011, 7'h19, 8);
    hold(4'b0111, 7'h12, 8);
    check("scan_digits", 32'(digits), 32'h5432);
    check("scan_valid",  32'(valid),  32'hF);
    check("scan_upd_n",  32'(upd_n),  32'd4);
    check("scan_err",    32'(err),    32'h0);

    // 2: short dwell on 1 must not capture; latency of the following dwell
    clear_counts();
    hold(4'b1110, 7'h79, 3);
    check("short_upd_n", 32'(upd_n), 32'd0);
    hold(4'b1110, 7'h24, 8);
    check("lat_upd_n",   32'(upd_n),       32'd1);
    check("lat_upd_at",  32'(last_upd_at), 32'd5);
    check("lat_digit0",  32'(digits[3:0]), 32'h2);

    // 3: unqualified anode patterns
    clear_counts();
    hold(4'b1100, 7'h40, 20);
    hold(4'b1111, 7'h40, 20);
    check("unq_upd_n",  32'(upd_n),  32'd0);
    check("unq_valid",  32'(valid),  32'hF);
    check("unq_digits", 32'(digits), 32'h5432);

    // 4: illegal pattern then recovery, err sticky
    clear_counts();
    hold(4'b1101, 7'h55, 8);
    check("ill_upd_n",  32'(upd_n),       32'd1);
    check("ill_err",    32'(err),         32'h1);
    check("ill_valid",  32'(valid),       32'hD);
    check("ill_digit1", 32'(digits[7:4]), 32'h3);
    hold(4'b1101, 7'h30, 8);
    check("rec_valid",  32'(valid), 32'hF);
    check("rec_err",    32'(err),   32'h1);

    // 6: blank after 9 on digit2, then reset mid-dwell
    hold(4'b1011, 7'h10, 8);
    check("nine_digits", 32'(digits), 32'h5932);
    clear_counts();
    hold(4'b1011, 7'h7F, 8);
    check("blank_upd_n",  32'(upd_n),        32'd1);
    check("blank_valid",  32'(valid),        32'hB);
    check("blank_digit2", 32'(digits[11:8]), 32'h9);
    hold(4'b0111, 7'h00, 2);
    rst = 1'b1;
    hold(4'b0111, 7'h00, 1);
    check("mrst_digits", 32'(digits), 32'h0);
    check("mrst_valid",  32'(valid),  32'h0);
    check("mrst_upd",    32'(upd),    32'h0);
    check("mrst_err",    32'(err),    32'h0);
    check("mrst_stale",  32'(stale),  32'h0);
    rst = 1'b0;
    clear_counts();
    hold(4'b0111, 7'h00, 8);
    check("post_upd_n",  32'(upd_n),       32'd1);
    check("post_upd_at", 32'(last_upd_at), 32'd5);
    check("post_digits", 32'(digits),      32'h8000);
    check("post_valid",  32'(valid),       32'h8);

    // 5: frozen scan, expiry, then a capture landing on the next expiry
    hold(4'b1110, 7'h40, 8);
    hold(4'b1101, 7'h79, 8);
    hold(4'b1011, 7'h24, 8);
    hold(4'b0111, 7'h30, 8);
    check("full_digits", 32'(digits), 32'h3210);
    check("full_valid",  32'(valid),  32'hF);
    clear_counts();
    hold(4'b1111, 7'h7F, T - 3);
    check("tmo_stale_n",  32'(stale_n),       32'd1);
    check("tmo_stale_at", 32'(last_stale_at), 32'(T - 3));
    check("tmo_valid",    32'(valid),         32'h0);
    check("tmo_digits",   32'(digits),        32'h3210);
    clear_counts();
    hold(4'b1111, 7'h7F, T - 5);
    hold(4'b1110, 7'h78, 8);
    check("tie_stale_n", 32'(stale_n),     32'd0);
    check("tie_upd_n",   32'(upd_n),       32'd1);
    check("tie_upd_at",  32'(last_upd_at), 32'd5);
    check("tie_valid",   32'(valid),       32'h1);
    check("tie_digit0",  32'(digits[3:0]), 32'h7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
